// File: rtl/anton_neopixel_apb_bridge.sv
// APB3 slave bridge onto the NeoPixel controller byte bus.
// Adds a local pointer and a packed 4-byte auto-increment write port.
module anton_neopixel_apb_bridge #(
    parameter int PTR_BITS = 13
) (
    input  logic        busClk,
    input  logic        busResetn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [15:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [13:0] busAddr,
    output logic [7:0]  busDataIn,
    output logic        busWrite,
    output logic        busRead,
    input  logic [7:0]  busDataOut
);

    typedef enum logic [2:0] {
        IDLE, WR, RD_ISSUE, RD_WAIT, PK, LOCAL, ERR
    } state_t;

    state_t              state;
    logic [PTR_BITS-1:0] ptr;
    logic [PTR_BITS-1:0] lane_addr;
    logic [1:0]          lane;
    logic [1:0]          next_lane;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                wr_q;
    logic                ptr_sel_q;

    logic [13:0] w;
    logic        misaligned;
    logic        bad_local;
    logic        fwd;
    logic        ptr_hit;
    logic        pk_hit;

    assign w          = PADDR[15:2];
    assign misaligned = |PADDR[1:0];
    assign bad_local  = w[13] && (w[2:1] == 2'b11);
    assign fwd        = !w[13] || !w[2];
    assign ptr_hit    = w[13] && (w[2:0] == 3'd4);
    assign pk_hit     = w[13] && (w[2:0] == 3'd5);

    assign next_lane  = lane + 2'd1;
    assign lane_addr  = ptr + PTR_BITS'(next_lane);

    // Read data from the controller arrives one cycle after busRead.
    assign PRDATA = (state == RD_WAIT) ? {24'b0, busDataOut} : rdata_q;

    always_ff @(posedge busClk or negedge busResetn) begin
        if (!busResetn) begin
            state     <= IDLE;
            ptr       <= '0;
            lane      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wr_q      <= 1'b0;
            ptr_sel_q <= 1'b0;
            PREADY    <= 1'b0;
            PSLVERR   <= 1'b0;
            busAddr   <= '0;
            busDataIn <= '0;
            busWrite  <= 1'b0;
            busRead   <= 1'b0;
        end else if (state != IDLE && !PSEL) begin
            state    <= IDLE;
            busWrite <= 1'b0;
            busRead  <= 1'b0;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        wdata_q   <= PWDATA;
                        wr_q      <= PWRITE;
                        ptr_sel_q <= ptr_hit;
                        if (misaligned || bad_local) begin
                            state   <= ERR;
                            PREADY  <= 1'b1;
                            PSLVERR <= 1'b1;
                        end else if (fwd) begin
                            busAddr <= w;
                            if (PWRITE) begin
                                state     <= WR;
                                busWrite  <= 1'b1;
                                busDataIn <= PWDATA[7:0];
                                PREADY    <= 1'b1;
                            end else begin
                                state   <= RD_ISSUE;
                                busRead <= 1'b1;
                            end
                        end else if (pk_hit && PWRITE) begin
                            state     <= PK;
                            lane      <= 2'd0;
                            busWrite  <= 1'b1;
                            busAddr   <= 14'(ptr);
                            busDataIn <= PWDATA[7:0];
                        end else begin
                            state   <= LOCAL;
                            PREADY  <= 1'b1;
                            rdata_q <= (ptr_hit && !PWRITE) ? 32'(ptr) : 32'd0;
                        end
                    end
                end
                WR: begin
                    state    <= IDLE;
                    busWrite <= 1'b0;
                    PREADY   <= 1'b0;
                end
                RD_ISSUE: begin
                    state   <= RD_WAIT;
                    busRead <= 1'b0;
                    PREADY  <= 1'b1;
                end
                RD_WAIT: begin
                    state  <= IDLE;
                    PREADY <= 1'b0;
                end
                PK: begin
                    if (lane == 2'd3) begin
                        state    <= IDLE;
                        ptr      <= ptr + PTR_BITS'(4);
                        busWrite <= 1'b0;
                        PREADY   <= 1'b0;
                    end else begin
                        lane      <= next_lane;
                        busAddr   <= 14'(lane_addr);
                        busDataIn <= wdata_q[{next_lane, 3'b000} +: 8];
                        PREADY    <= (next_lane == 2'd3);
                    end
                end
                LOCAL: begin
                    if (wr_q && ptr_sel_q) begin
                        ptr <= wdata_q[PTR_BITS-1:0];
                    end
                    state   <= IDLE;
                    PREADY  <= 1'b0;
                    rdata_q <= '0;
                end
                ERR: begin
                    state   <= IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_anton_neopixel_apb_bridge.sv
// Bench for anton_neopixel_apb_bridge: directed plan steps plus
// random APB traffic against a transaction-level reference model.
module tb_anton_neopixel_apb_bridge;

    logic        busClk = 1'b0;
    logic        busResetn;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [15:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [13:0] busAddr;
    logic [7:0]  busDataIn;
    logic        busWrite;
    logic        busRead;
    logic [7:0]  busDataOut;

    always #5 busClk = ~busClk;

    anton_neopixel_apb_bridge #(.PTR_BITS(13)) dut (
        .busClk     (busClk),
        .busResetn  (busResetn),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .busAddr    (busAddr),
        .busDataIn  (busDataIn),
        .busWrite   (busWrite),
        .busRead    (busRead),
        .busDataOut (busDataOut)
    );

    // Controller stand-in: logs byte writes, returns registered read data.
    logic [7:0]  ctrl_mem [16384];
    logic [21:0] wlog [$];
    int          rd_cnt  = 0;
    bit          both_hi = 1'b0;

    always @(posedge busClk) begin
        if (busWrite) wlog.push_back({busAddr, busDataIn});
        if (busRead) rd_cnt <= rd_cnt + 1;
        if (busWrite && busRead) both_hi <= 1'b1;
    end

    always @(posedge busClk or negedge busResetn) begin
        if (!busResetn) busDataOut <= 8'd0;
        else if (busRead) busDataOut <= ctrl_mem[busAddr];
    end

    int vectors = 0;
    int miscompares = 0;
    int ptr_m = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input bit wr, input logic [15:0] addr,
                       input logic [31:0] data, output logic [31:0] rdata);
        logic [21:0] exp_w [$];
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_cyc, exp_rd, rd0, cyc, w;
        w         = int'(addr) / 4;
        exp_rdata = 0;
        exp_err   = 0;
        exp_cyc   = 1;
        exp_rd    = 0;
        if (addr % 4 != 0) begin
            exp_err = 1;
        end else if (w < 8192 || (w & 4) == 0) begin
            if (wr) begin
                exp_w.push_back({14'(w), data[7:0]});
            end else begin
                exp_cyc   = 2;
                exp_rd    = 1;
                exp_rdata = 32'(ctrl_mem[w]);
            end
        end else if (w % 8 == 4) begin
            if (wr) ptr_m = int'(data % 8192);
            else exp_rdata = 32'(ptr_m);
        end else if (w % 8 == 5) begin
            if (wr) begin
                for (int i = 0; i < 4; i++)
                    exp_w.push_back({14'((ptr_m + i) % 8192), 8'(data >> (8 * i))});
                exp_cyc = 4;
                ptr_m   = (ptr_m + 4) % 8192;
            end
        end else begin
            exp_err = 1;
        end

        wlog.delete();
        rd0     = rd_cnt;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
        @(posedge busClk); #1;
        PENABLE = 1'b1;
        cyc = 1;
        while (!PREADY && cyc < 16) begin
            @(posedge busClk); #1;
            cyc++;
        end
        rdata = PRDATA;
        check($sformatf("cycles@%h", addr), 64'(cyc), 64'(exp_cyc));
        check($sformatf("prdata@%h", addr), 64'(PRDATA), 64'(exp_rdata));
        check($sformatf("pslverr@%h", addr), 64'(PSLVERR), 64'(exp_err));
        @(posedge busClk); #1;
        check($sformatf("nwrites@%h", addr), 64'(wlog.size()), 64'(exp_w.size()));
        foreach (exp_w[i])
            if (i < wlog.size())
                check($sformatf("wr%0d@%h", i, addr), 64'(wlog[i]), 64'(exp_w[i]));
        check($sformatf("nreads@%h", addr), 64'(rd_cnt - rd0), 64'(exp_rd));
    endtask

    task automatic idle();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        @(posedge busClk); #1;
    endtask

    logic [31:0] rd;
    logic [15:0] a;
    logic [13:0] wr_w;

    initial begin
        for (int i = 0; i < 16384; i++) ctrl_mem[i] = 8'($urandom);
        busResetn = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        PWRITE    = 1'b0;
        PADDR     = '0;
        PWDATA    = '0;
        repeat (2) @(posedge busClk);
        #1;
        check("rst_outputs",
              {PRDATA, PREADY, PSLVERR, busAddr, busDataIn, busWrite, busRead}, 0);
        busResetn = 1'b1;
        @(posedge busClk); #1;

        txn(1, 16'h0010, 32'h0000_00A5, rd);
        ctrl_mem[14'h2001] = 8'h3C;
        txn(0, 16'h8004, 32'h0, rd);
        check("plan_rd", rd, 32'h0000_003C);

        txn(1, 16'h8010, 32'd8, rd);
        txn(1, 16'h8014, 32'h1122_3344, rd);
        txn(0, 16'h8010, 32'h0, rd);
        check("plan_ptr12", rd, 32'd12);

        txn(1, 16'h8010, 32'd8190, rd);
        txn(1, 16'h8014, 32'hDDCC_BBAA, rd);
        txn(0, 16'h8010, 32'h0, rd);
        check("plan_ptr2", rd, 32'd2);

        txn(1, 16'h0002, 32'h1234_5678, rd);
        txn(0, 16'h8018, 32'h0, rd);
        txn(0, 16'h8014, 32'h0, rd);
        check("plan_pkrd", rd, 32'd0);
        idle();

        // Reset during lane 1 of a packed write.
        txn(1, 16'h8010, 32'd20, rd);
        wlog.delete();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 16'h8014; PWDATA = 32'hCAFE_F00D;
        @(posedge busClk); #1;
        PENABLE = 1'b1;
        check("rab_lane0", {busWrite, busAddr, busDataIn}, {1'b1, 14'd20, 8'h0D});
        @(posedge busClk); #1;
        check("rab_lane1", {busWrite, busAddr, busDataIn}, {1'b1, 14'd21, 8'hF0});
        busResetn = 1'b0;
        #1;
        check("rab_zero",
              {PRDATA, PREADY, PSLVERR, busAddr, busDataIn, busWrite, busRead}, 0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge busClk); #1;
        busResetn = 1'b1;
        check("rab_nwrites", 64'(wlog.size()), 64'd1);
        ptr_m = 0;
        @(posedge busClk); #1;
        txn(0, 16'h8010, 32'h0, rd);
        check("rab_ptr", rd, 32'd0);

        // PSEL drop during lane 2.
        txn(1, 16'h8010, 32'd100, rd);
        wlog.delete();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 16'h8014; PWDATA = 32'h5566_7788;
        @(posedge busClk); #1;
        PENABLE = 1'b1;
        @(posedge busClk); #1;
        @(posedge busClk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge busClk); #1;
        check("pab_quiet", {busWrite, PREADY}, 2'b00);
        check("pab_nwrites", 64'(wlog.size()), 64'd3);
        if (wlog.size() > 2) check("pab_lane2", 64'(wlog[2]), {14'd102, 8'h66});
        @(posedge busClk); #1;
        txn(0, 16'h8010, 32'h0, rd);
        check("pab_ptr", rd, 32'd100);

        for (int n = 0; n < 120; n++) begin
            wr_w = 14'($urandom);
            case ($urandom_range(0, 6))
                0: wr_w[13] = 1'b0;
                1: begin wr_w[13] = 1'b1; wr_w[2] = 1'b0; end
                2: begin wr_w[13] = 1'b1; wr_w[2:0] = 3'd4; end
                3, 6: begin wr_w[13] = 1'b1; wr_w[2:0] = 3'd5; end
                4: begin wr_w[13] = 1'b1; wr_w[2:1] = 2'b11; end
                default: ;
            endcase
            a = {wr_w, 2'b00};
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            txn(1'($urandom), a, $urandom, rd);
            if ($urandom_range(0, 3) == 0) idle();
        end

        check("no_overlap", 64'(both_hi), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/anton_neopixel_apb_bridge.md
Name: anton_neopixel_apb_bridge

Overview:
- APB3 slave front-end that drives the 8-bit byte bus of the NeoPixel raw controller: busAddr, busDataIn, busWrite, busRead and busDataOut.
- Converts 32-bit word-aligned APB transfers into byte-bus strobes and inserts wait states for the controller's registered read data.
- Adds a bridge-local auto-incrementing "packed" data port, so one 32-bit APB write loads four consecutive pixel bytes.
- Sits between the SoC APB interconnect and the controller, on the controller's single bus clock.

Parameters:
- PTR_BITS, 13, width of the local packed-write pointer. Matches the 13-bit byte index of the pixel buffer.

Ports:
- busClk  input  1  single clock for APB and the byte bus.
- busResetn  input  1  asynchronous, active-low reset.
- PSEL  input  1  APB select.
- PENABLE  input  1  APB access phase.
- PWRITE  input  1  APB direction, 1 = write.
- PADDR  input  16  APB byte address.
- PWDATA  input  32  APB write data.
- PRDATA  output  32  APB read data.
- PREADY  output  1  APB transfer complete.
- PSLVERR  output  1  APB error, valid when PREADY=1.
- busAddr  output  14  byte-bus address.
- busDataIn  output  8  byte-bus write data.
- busWrite  output  1  byte-bus write strobe.
- busRead  output  1  byte-bus read strobe.
- busDataOut  input  8  registered read data from the controller, valid the cycle after busRead.

Behaviour:
- Reset (busResetn=0, asynchronous):
  - PRDATA=0, PREADY=0, PSLVERR=0, busAddr=0, busDataIn=0, busWrite=0, busRead=0.
  - PTR=0, FSM=IDLE.
  - Applies mid-transfer too: a pending packed sequence is abandoned.
- Address decode, with W=PADDR[15:2]:
  - W[13]=0: pixel byte, forwarded with busAddr=W.
  - W[13]=1 and W[2]=0: controller register, forwarded with busAddr=W.
  - W[13]=1 and W[2:0]=4: local PTR, read/write. Write loads PWDATA[PTR_BITS-1:0]; read returns it zero-extended.
  - W[13]=1 and W[2:0]=5: packed data port. Write-only; a read returns 0 with no error.
  - W[13]=1 and W[2:0]=6 or 7: PSLVERR=1, no byte-bus activity.
  - PADDR[1:0]!=0: PSLVERR=1, no byte-bus activity, PTR unchanged.
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, PK, LOCAL, ERR. Every outgoing byte-bus signal is registered.
- IDLE:
  - Waits for a setup phase (PSEL=1, PENABLE=0).
  - On the setup edge it captures PADDR and PWDATA and selects the next state.
  - Forwarded write → WR; forwarded read → RD_ISSUE; PTR access or packed read → LOCAL; packed write → PK with lane=0; error → ERR.
- WR (1 access cycle):
  - busWrite=1, busAddr=W, busDataIn=PWDATA[7:0], PREADY=1.
  - Next state IDLE, busWrite=0.
- RD_ISSUE (access cycle 1): busRead=1 for exactly one cycle, PREADY=0.
- RD_WAIT (access cycle 2): PRDATA={24'b0,busDataOut}, PREADY=1, busRead=0. A forwarded read therefore takes 2 access cycles.
- PK (4 access cycles, lane 0..3):
  - busWrite=1, busAddr={1'b0,PTR+lane}, busDataIn=PWDATA[8*lane+7:8*lane].
  - PREADY=1 only on lane 3.
  - On the lane-3 edge, PTR <= PTR+4, modulo 2^PTR_BITS.
  - Lane addresses also wrap modulo 2^PTR_BITS: lanes at PTR=8190 write 8190, 8191, 0, 1.
- LOCAL and ERR: PREADY=1 in the first access cycle. PSLVERR=1 only in ERR. A PTR write takes effect on that edge.
- PRDATA is 0 whenever PREADY=0 or the transfer is a write.
- PSLVERR is 0 whenever PREADY=0.
- If PSEL drops before PREADY, the FSM returns to IDLE on the next edge and stops any remaining packed lanes. Lanes already written stay written, and PTR is not incremented.
- Back-to-back transfers: a new setup phase directly after PREADY is accepted with no idle cycle in between.
- busWrite and busRead are never high in the same cycle.

Test Plan:
- Forwarded pixel write: PADDR=0x0010, PWDATA=0xA5 → busWrite high for 1 cycle with busAddr=4 and busDataIn=0xA5; PREADY in the first access cycle.
- Forwarded register read: busDataOut=0x3C is returned the cycle after busRead, with PADDR=0x8004.
  - busRead is high for 1 cycle with busAddr=0x2001.
  - PRDATA=0x0000003C with PREADY in the second access cycle.
- Packed write: write PTR=8 at 0x8010, then 0x11223344 at 0x8014 → byte writes (8,0x44), (9,0x33), (10,0x22), (11,0x11) on consecutive cycles. PREADY on the 4th; a PTR read at 0x8010 then returns 12.
- Packed pointer wrap: PTR=8190, packed write 0xDDCCBBAA → byte writes at addresses 8190, 8191, 0, 1 with data 0xAA, 0xBB, 0xCC, 0xDD; PTR becomes 2.
- Errors:
  - PADDR=0x0002 → PSLVERR=1, no byte-bus strobe.
  - PADDR=0x8018 → PSLVERR=1, no byte-bus strobe.
  - Packed-port read at 0x8014 → PRDATA=0, PSLVERR=0.
- Aborts:
  - busResetn asserted during lane 1 of a packed write → all outputs 0 immediately, PTR=0.
  - Separately, PSEL dropped during lane 2 → lane 3 is not written and PTR is unchanged.
